// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the single-issue MIPS pipeline.
// Holds the PC and drives it to the combinational program ROM. Captures the
// returned instruction into the IF/ID register. Selects the next PC from the
// sequential, branch, jump or register-jump source, under stall and flush control.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   stall                 hold PC and IF/ID
//   flush                 load a bubble into IF/ID
//   branch_taken/target   conditional branch redirect
//   jump/jump_target      j/jal redirect
//   jr/jr_target          register-jump redirect (highest priority)
//   instruction           ROM data for the current pc
//   pc                    fetch byte address to the ROM
//   if_id_instruction     registered instruction to decode
//   if_id_pc_plus4        registered pc+4 of that instruction
//   if_id_valid           IF/ID holds a real instruction
//   fetch_count           number of valid captures (wraps)
//   fault, fault_code     sticky: [0] misaligned target, [1] PC outside ROM
module fetch_stage #(
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]    RESET_PC     = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0]    TEXT_BASE    = 32'h0040_0000,
  parameter int unsigned              MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0]    NOP          = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [DATA_WIDTH-1:0] jump_target,
  input  logic                  jr,
  input  logic [DATA_WIDTH-1:0] jr_target,
  input  logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] if_id_instruction,
  output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
  output logic                  if_id_valid,
  output logic [31:0]           fetch_count,
  output logic                  fault,
  output logic [1:0]            fault_code
);

  localparam int unsigned EXT_W = DATA_WIDTH + 1;
  // One extra bit so a ROM that ends exactly at 2^DATA_WIDTH cannot overflow.
  localparam logic [EXT_W-1:0] ROM_LO = EXT_W'(TEXT_BASE);
  localparam logic [EXT_W-1:0] ROM_HI = EXT_W'(TEXT_BASE) + EXT_W'(4 * MEMORY_DEPTH);

  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_if_id_instruction;
  logic [DATA_WIDTH-1:0] r_if_id_pc_plus4;
  logic                  r_if_id_valid;
  logic [31:0]           r_fetch_count;
  logic                  r_fault;
  logic [1:0]            r_fault_code;

  logic                  w_redirect;
  logic                  w_accept;
  logic                  w_bubble;
  logic                  w_capture;
  logic                  w_out_of_range;
  logic [DATA_WIDTH-1:0] w_target;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_pc_next;
  logic [1:0]            w_fault_code_next;

  // Redirect selection, IF/ID action and next-PC decision.
  always_comb begin
    w_redirect        = jr | jump | branch_taken;
    w_target          = branch_target;
    w_accept          = 1'b0;
    w_bubble          = 1'b0;
    w_capture         = 1'b0;
    w_pc_plus4        = r_pc + DATA_WIDTH'(4);
    w_pc_next         = r_pc;
    w_out_of_range    = 1'b0;
    w_fault_code_next = r_fault_code;

    if (jr) begin
      w_target = jr_target;
    end else if (jump) begin
      w_target = jump_target;
    end

    // A stalled redirect is not consumed; the source keeps it asserted.
    w_accept  = w_redirect & ~stall;
    // Flush squashes even while stalled; an accepted redirect kills the wrong-path fetch.
    w_bubble  = flush | w_accept;
    w_capture = ~w_bubble & ~stall;

    if (!stall) begin
      if (w_accept) begin
        w_pc_next = {w_target[DATA_WIDTH-1:2], 2'b00};
      end else begin
        w_pc_next = w_pc_plus4;
      end
    end

    w_out_of_range = ({1'b0, r_pc} < ROM_LO) || ({1'b0, r_pc} >= ROM_HI);

    if (w_accept && (w_target[1:0] != 2'b00)) begin
      w_fault_code_next[0] = 1'b1;
    end
    if (w_capture && w_out_of_range) begin
      w_fault_code_next[1] = 1'b1;
    end
  end

  // PC, IF/ID, counter and sticky fault registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc                <= RESET_PC;
      r_if_id_instruction <= NOP;
      r_if_id_pc_plus4    <= '0;
      r_if_id_valid       <= 1'b0;
      r_fetch_count       <= '0;
      r_fault             <= 1'b0;
      r_fault_code        <= 2'b00;
    end else begin
      r_pc         <= w_pc_next;
      r_fault_code <= w_fault_code_next;
      r_fault      <= |w_fault_code_next;
      if (w_bubble) begin
        r_if_id_instruction <= NOP;
        r_if_id_pc_plus4    <= '0;
        r_if_id_valid       <= 1'b0;
      end else if (w_capture) begin
        r_if_id_instruction <= instruction;
        r_if_id_pc_plus4    <= w_pc_plus4;
        r_if_id_valid       <= 1'b1;
        r_fetch_count       <= r_fetch_count + 32'd1;
      end
    end
  end

  assign pc                = r_pc;
  assign if_id_instruction = r_if_id_instruction;
  assign if_id_pc_plus4    = r_if_id_pc_plus4;
  assign if_id_valid       = r_if_id_valid;
  assign fetch_count       = r_fetch_count;
  assign fault             = r_fault;
  assign fault_code        = r_fault_code;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a behavioural ROM and
// a rule-level reference model; directed scenarios followed by random traffic.
module tb_fetch_stage;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0, flush = 1'b0;
  logic        branch_taken = 1'b0, jump = 1'b0, jr = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0, jr_target = '0;
  logic [31:0] instruction;
  logic [31:0] pc, if_id_instruction, if_id_pc_plus4, fetch_count;
  logic        if_id_valid, fault;
  logic [1:0]  fault_code;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        v;
    logic [31:0] cnt;
    logic [1:0]  fc;
  } snap_t;

  snap_t exp_q[$];

  // Reference model state.
  logic [31:0] m_pc, m_ins, m_p4, m_cnt;
  logic        m_v;
  logic [1:0]  m_fc;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    if (off >= 0 && off < 4 * DEPTH) return 32'h2008_0001 + 32'(off / 4);
    return 32'hBAD0_0000 ^ a;
  endfunction

  assign instruction = rom(pc);

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
    .instruction(instruction), .pc(pc), .if_id_instruction(if_id_instruction),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count), .fault(fault), .fault_code(fault_code)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = BASE; m_ins = '0; m_p4 = '0; m_v = 1'b0; m_cnt = '0; m_fc = 2'b00;
  endtask

  // Applies the fetch rules for one clock edge to the model.
  task automatic model_step(input bit s, input bit f, input bit b, input logic [31:0] bt,
                            input bit j, input logic [31:0] jt, input bit r, input logic [31:0] rt);
    bit          acc, in_rom;
    logic [31:0] tgt;
    tgt    = r ? rt : (j ? jt : bt);
    acc    = (r || j || b) && !s;
    in_rom = (longint'(m_pc) >= longint'(BASE)) && (longint'(m_pc) < longint'(BASE) + 4 * DEPTH);
    if (acc && (tgt % 4) != 0) m_fc[0] = 1'b1;
    if (f || acc) begin
      m_ins = '0; m_p4 = '0; m_v = 1'b0;
    end else if (!s) begin
      if (!in_rom) m_fc[1] = 1'b1;
      m_ins = rom(m_pc);
      m_p4  = m_pc + 32'd4;
      m_v   = 1'b1;
      m_cnt = m_cnt + 32'd1;
    end
    if (!s) m_pc = acc ? (tgt - (tgt % 4)) : m_pc + 32'd4;
  endtask

  // Called at a falling edge: drive inputs, predict, return at the next falling edge.
  task automatic cyc(input bit s, input bit f, input bit b, input logic [31:0] bt,
                     input bit j, input logic [31:0] jt, input bit r, input logic [31:0] rt);
    snap_t e;
    stall = s; flush = f; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt; jr = r; jr_target = rt;
    model_step(s, f, b, bt, j, jt, r, rt);
    e.pc = m_pc; e.ins = m_ins; e.p4 = m_p4; e.v = m_v; e.cnt = m_cnt; e.fc = m_fc;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pc"},    pc, BASE);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'd0);
    chk({tag, "_ins"},   if_id_instruction, 32'd0);
    chk({tag, "_p4"},    if_id_pc_plus4, 32'd0);
    chk({tag, "_cnt"},   fetch_count, 32'd0);
    chk({tag, "_fault"}, {30'd0, fault_code}, 32'd0);
    chk({tag, "_flag"},  32'(fault), 32'd0);
  endtask

  // Called at a falling edge; holds reset across one rising edge.
  task automatic do_reset(input bit check);
    stall = 0; flush = 0; branch_taken = 0; jump = 0; jr = 0;
    reset = 1'b1;
    #1;
    if (check) chk_reset_values("reset");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    t = BASE + 32'(4 * $urandom_range(0, 40));
    if ($urandom_range(0, 7) == 0) t = t + 32'($urandom_range(1, 3));
    return t;
  endfunction

  // Scoreboard monitor: compares every predicted edge just after it happens.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pc",    pc, e.pc);
        chk("sb_ins",   if_id_instruction, e.ins);
        chk("sb_p4",    if_id_pc_plus4, e.p4);
        chk("sb_valid", 32'(if_id_valid), 32'(e.v));
        chk("sb_cnt",   fetch_count, e.cnt);
        chk("sb_fcode", {30'd0, fault_code}, {30'd0, e.fc});
        chk("sb_fault", 32'(fault), 32'(|e.fc));
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset(1);

    // Free-running fetch from the text base.
    idle(4);
    chk("free_pc",  pc, 32'h0040_0010);
    chk("free_cnt", fetch_count, 32'd4);
    chk("free_p4",  if_id_pc_plus4, 32'h0040_0010);
    chk("free_ins", if_id_instruction, 32'h2008_0004);

    // Taken branch squashes the wrong-path fetch.
    do_reset(0);
    idle(2);
    chk("br_pc_before", pc, 32'h0040_0008);
    cyc(0, 0, 1, 32'h0040_0040, 0, '0, 0, '0);
    chk("br_pc",    pc, 32'h0040_0040);
    chk("br_valid", 32'(if_id_valid), 32'd0);
    chk("br_ins",   if_id_instruction, 32'd0);
    chk("br_cnt",   fetch_count, 32'd2);

    // Stall holds a pending jump for three cycles.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, '0, 1, 32'h0040_0020, 0, '0);
      chk("stall_pc",  pc, 32'h0040_0040);
      chk("stall_cnt", fetch_count, 32'd2);
    end
    cyc(0, 0, 0, '0, 1, 32'h0040_0020, 0, '0);
    chk("jump_pc",    pc, 32'h0040_0020);
    chk("jump_valid", 32'(if_id_valid), 32'd0);

    // Priority jr > jump > branch.
    cyc(0, 0, 1, 32'h0040_0300, 1, 32'h0040_0200, 1, 32'h0040_0100);
    chk("prio_pc", pc, 32'h0040_0100);

    // Misaligned jr target, then run off the end of the ROM.
    cyc(0, 0, 0, '0, 0, '0, 1, 32'h0040_0006);
    chk("mis_pc",    pc, 32'h0040_0004);
    chk("mis_fcode", {30'd0, fault_code}, 32'd1);
    chk("mis_fault", 32'(fault), 32'd1);
    idle(33);
    chk("range_fcode", {30'd0, fault_code}, 32'd3);
    idle(3);
    chk("sticky_fcode", {30'd0, fault_code}, 32'd3);
    chk("sticky_fault", 32'(fault), 32'd1);

    // Asynchronous reset mid-cycle.
    do_reset(0);
    idle(7);
    chk("async_pc_before", pc, 32'h0040_001C);
    #2 reset = 1'b1;
    #1;
    chk("async_pc",    pc, BASE);
    chk("async_valid", 32'(if_id_valid), 32'd0);
    chk("async_cnt",   fetch_count, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        cyc($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, rnd_tgt(),
            $urandom_range(0, 9) == 0, rnd_tgt(),
            $urandom_range(0, 11) == 0, rnd_tgt());
      end
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
